// File: rtl/spi_main_x2_tx_pkg.sv
// Shared definitions for the write-only DAC SPI main: state encoding,
// frame padding and inter-frame gap length.
package spi_main_x2_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int PAD_BITS   = 6;
  localparam int GAP_CYCLES = 2;

  // Frame = zero padding + PD1:PD0 + data word.
  function automatic int frame_width(input int word_width);
    return word_width + PAD_BITS + 2;
  endfunction

endpackage

// File: rtl/spi_main_x2_tx.sv
// Write-only SPI main (mode 1) sending {pad, power_state, sample} frames
// MSB first with SCLK at half the system clock; repeats while load is high.
//
// state    | meaning
// ST_IDLE  | csb high, waiting for load to capture a frame
// ST_SHIFT | csb low, two cycles per bit (sclk high, then sclk low)
// ST_GAP   | csb high for GAP_CYCLES before returning to IDLE
module spi_main_x2_tx
  import spi_main_x2_tx_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] parallel_in,
  input  logic [1:0]            power_state,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb
);

  localparam int FRAME_W = frame_width(WORD_WIDTH);
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_START = GAP_W'(GAP_CYCLES - 1);

  state_e               r_state;
  logic [FRAME_W-1:0]   r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_phase_b;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_sclk;
  logic                 r_mosi;
  logic                 r_csb;

  logic [FRAME_W-1:0]   w_frame;

  assign w_frame = {{PAD_BITS{1'b0}}, power_state, parallel_in};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_phase_b <= 1'b0;
      r_gap_cnt <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_csb     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
          r_csb  <= 1'b1;
          if (load) begin
            r_state   <= ST_SHIFT;
            r_shift   <= w_frame;
            r_bit_cnt <= LAST_BIT;
            r_phase_b <= 1'b1;
            r_sclk    <= 1'b1;
            r_mosi    <= w_frame[FRAME_W-1];
            r_csb     <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (r_phase_b) begin
            r_sclk    <= 1'b0;
            r_phase_b <= 1'b0;
          end else if (r_bit_cnt == '0) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_START;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_csb     <= 1'b1;
          end else begin
            // Next bit goes out with the sclk rising edge (mode 1).
            r_bit_cnt <= r_bit_cnt - 1'b1;
            r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
            r_mosi    <= r_shift[FRAME_W-2];
            r_sclk    <= 1'b1;
            r_phase_b <= 1'b1;
          end
        end

        ST_GAP: begin
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
          r_csb  <= 1'b1;
          if (r_gap_cnt == '0) r_state <= ST_IDLE;
          else                 r_gap_cnt <= r_gap_cnt - 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_sclk  <= 1'b0;
          r_mosi  <= 1'b0;
          r_csb   <= 1'b1;
        end
      endcase
    end
  end

  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign csb  = r_csb;

endmodule

// File: tb/tb_spi_main_x2_tx.sv
// Directed + randomized bench for spi_main_x2_tx: frames are rebuilt from
// sclk falling edges and compared against {pad, ps, data} arithmetic.
module tb_spi_main_x2_tx;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b1;
  logic        load    = 1'b0;
  logic [15:0] parallel_in = '0;
  logic [1:0]  power_state = '0;
  logic        sclk, mosi, csb;

  logic        load8 = 1'b0;
  logic [7:0]  parallel_in8 = '0;
  logic [1:0]  power_state8 = '0;
  logic        sclk8, mosi8, csb8;

  int n_assert = 0;
  int n_fail   = 0;
  bit toggle_en = 1'b0;

  always #5 sys_clk = ~sys_clk;

  spi_main_x2_tx #(.WORD_WIDTH(16)) dut (
    .sys_clk(sys_clk), .rst(rst), .load(load), .parallel_in(parallel_in),
    .power_state(power_state), .sclk(sclk), .mosi(mosi), .csb(csb)
  );

  spi_main_x2_tx #(.WORD_WIDTH(8)) dut8 (
    .sys_clk(sys_clk), .rst(rst), .load(load8), .parallel_in(parallel_in8),
    .power_state(power_state8), .sclk(sclk8), .mosi(mosi8), .csb(csb8)
  );

  function automatic logic [31:0] model_frame(input logic [1:0] ps, input logic [31:0] data, input int ww);
    return (32'(ps) << ww) | data;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tog();
    if (toggle_en) begin
      parallel_in = 16'($urandom);
      power_state = 2'($urandom);
    end
  endtask

  // Samples now, then on each falling sys_clk edge; collects one bit per sclk fall.
  task automatic observe_frame(input bit sel8, input bit drop_load, input int budget,
                               output logic [31:0] got, output int nbits,
                               output int low_cyc, output int wait_cyc, output bit ok);
    logic prev_sclk;
    int t;
    got = '0; nbits = 0; low_cyc = 0; wait_cyc = 0; ok = 1'b0;
    prev_sclk = 1'b0; t = 0;
    while ((sel8 ? csb8 : csb) === 1'b1 && t < budget) begin
      @(negedge sys_clk); tog(); t++;
    end
    wait_cyc = t;
    if ((sel8 ? csb8 : csb) !== 1'b0) return;
    if (drop_load) load = 1'b0;
    while ((sel8 ? csb8 : csb) === 1'b0 && t < budget) begin
      low_cyc++;
      if (prev_sclk && (sel8 ? sclk8 : sclk) === 1'b0) begin
        got = {got[30:0], (sel8 ? mosi8 : mosi)};
        nbits++;
      end
      prev_sclk = (sel8 ? sclk8 : sclk);
      @(negedge sys_clk); tog(); t++;
    end
    ok = ((sel8 ? csb8 : csb) === 1'b1);
  endtask

  initial begin
    logic [31:0] got, exp_f;
    logic [15:0] d;
    logic [1:0]  p;
    int nb, lc, wc, bad;
    bit ok;

    repeat (3) @(negedge sys_clk);
    check("reset_csb",  32'(csb),  32'd1);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    // Single frame, one-cycle load pulse
    parallel_in = 16'ha5a5; power_state = 2'b11; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    observe_frame(1'b0, 1'b0, 200, got, nb, lc, wc, ok);
    check("single_done",  32'(ok), 32'd1);
    check("single_frame", got, model_frame(2'b11, 32'h0000a5a5, 16));
    check("single_bits",  32'(nb), 32'd24);
    check("single_csb_low", 32'(lc), 32'd48);

    // Back-to-back with inputs changed right after the first capture
    repeat (5) @(negedge sys_clk);
    parallel_in = 16'ha5a5; power_state = 2'b11; load = 1'b1;
    @(negedge sys_clk);
    parallel_in = 16'h04d8; power_state = 2'b01;
    observe_frame(1'b0, 1'b0, 200, got, nb, lc, wc, ok);
    check("b2b_first_done",  32'(ok), 32'd1);
    check("b2b_first_frame", got, 32'h0003a5a5);
    observe_frame(1'b0, 1'b1, 200, got, nb, lc, wc, ok);
    check("b2b_second_done",  32'(ok), 32'd1);
    check("b2b_second_frame", got, model_frame(2'b01, 32'h000004d8, 16));
    check("b2b_gap", 32'(wc), 32'd3);
    check("b2b_csb_low", 32'(lc), 32'd48);

    // Random frames with inputs churning every cycle while shifting
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge sys_clk);
      d = 16'($urandom); p = 2'($urandom);
      parallel_in = d; power_state = p; load = 1'b1;
      @(negedge sys_clk);
      load = 1'b0; toggle_en = 1'b1;
      observe_frame(1'b0, 1'b0, 200, got, nb, lc, wc, ok);
      toggle_en = 1'b0;
      exp_f = model_frame(p, 32'(d), 16);
      check("rand_done",  32'(ok), 32'd1);
      check("rand_frame", got, exp_f);
      check("rand_bits",  32'(nb), 32'd24);
    end

    // Idle: nothing moves without load
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (sclk !== 1'b0 || mosi !== 1'b0 || csb !== 1'b1) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Asynchronous reset mid-frame
    parallel_in = 16'hffff; power_state = 2'b11; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    repeat (9) @(negedge sys_clk);
    check("pre_reset_active", 32'(csb), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_csb",  32'(csb),  32'd1);
    check("async_rst_sclk", 32'(sclk), 32'd0);
    check("async_rst_mosi", 32'(mosi), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (sclk !== 1'b0 || mosi !== 1'b0 || csb !== 1'b1) bad++;
    end
    check("post_reset_quiet", 32'(bad), 32'd0);

    // WORD_WIDTH = 8 instance
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom_range(0, 255)); p = 2'($urandom);
      parallel_in8 = d[7:0]; power_state8 = p; load8 = 1'b1;
      @(negedge sys_clk);
      load8 = 1'b0;
      parallel_in8 = ~d[7:0];
      observe_frame(1'b1, 1'b0, 200, got, nb, lc, wc, ok);
      check("w8_done",    32'(ok), 32'd1);
      check("w8_frame",   got, model_frame(p, 32'(d[7:0]), 8));
      check("w8_bits",    32'(nb), 32'd16);
      check("w8_csb_low", 32'(lc), 32'd32);
      repeat (3) @(negedge sys_clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
